// File: rtl/reg_skid_reader_pkg.sv
// rtl/reg_skid_reader_pkg.sv - shared types and helpers for the skid-buffer reader
package reg_skid_reader_pkg;

    localparam int DATA_W_DEF = 21;

    // Occupancy state of the two-entry buffer: number of held words.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // Words held for a given state; the encodings already equal the count,
    // so anything outside the legal set maps to 0 and 3 can never appear.
    function automatic logic [1:0] level_of(input state_t st);
        case (st)
            ST_BUSY: level_of = 2'd1;
            ST_FULL: level_of = 2'd2;
            default: level_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/reg_skid_reader_if.sv
// rtl/reg_skid_reader_if.sv - producer/reader handshake bundle for reg_skid_reader
//  s_valid_i/s_ready_o/s_data_i : producer side word transfer
//  m_valid_o/m_ready_i/m_data_o : reader side word transfer
//  level_o                      : words currently held (0..2)
//  modport slave  : the buffer itself
//  modport master : the environment (producer + reader)
interface reg_skid_reader_if #(
    parameter int DATA_W = 21
);
    logic              s_valid_i;
    logic              s_ready_o;
    logic [DATA_W-1:0] s_data_i;
    logic              m_valid_o;
    logic              m_ready_i;
    logic [DATA_W-1:0] m_data_o;
    logic [1:0]        level_o;

    modport slave (
        input  s_valid_i, s_data_i, m_ready_i,
        output s_ready_o, m_valid_o, m_data_o, level_o
    );

    modport master (
        output s_valid_i, s_data_i, m_ready_i,
        input  s_ready_o, m_valid_o, m_data_o, level_o
    );
endinterface

// File: rtl/reg_skid_reader_data_reg.sv
// rtl/reg_skid_reader_data_reg.sv - enable/reset data register (main and skid storage)
//  clk_i  : clock
//  arst_i : asynchronous active-high reset to RST_VAL
//  cke_i  : clock enable; 0 holds q
//  data_e : load d into q
//  data_r : synchronous clear to RST_VAL, wins over data_e
//  d / q  : data in / registered data out
module reg_skid_reader_data_reg #(
    parameter int                DATA_W  = 21,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              cke_i,
    input  logic              data_e,
    input  logic              data_r,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            q <= RST_VAL;
        end else if (cke_i) begin
            if (data_r) begin
                q <= RST_VAL;
            end else if (data_e) begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/reg_skid_reader.sv
// rtl/reg_skid_reader.sv - two-entry registered skid buffer draining a data word to a reader
//  clk_i  : clock, all state on posedge
//  arst_i : asynchronous active-high reset, drops held words
//  cke_i  : clock enable; 0 freezes all state and outputs
//  clr_i  : synchronous clear (qualified by cke_i), beats simultaneous transfers
//  bus    : slave side of reg_skid_reader_if (producer in, reader out, level)
module reg_skid_reader
    import reg_skid_reader_pkg::*;
#(
    parameter int                DATA_W  = DATA_W_DEF,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic             cke_i,
    input  logic             clr_i,
    reg_skid_reader_if.slave bus
);

    state_t            state_q;
    state_t            state_nxt;
    logic              s_ready_q;
    logic              m_valid_q;
    logic [1:0]        level_q;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] main_d;
    logic              main_load;
    logic              main_from_skid;
    logic              skid_load;
    logic              xfer_in;
    logic              xfer_out;

    // Handshakes use the registered ready/valid; cke_i gating happens in the
    // flops, so nothing moves while the clock enable is low.
    assign xfer_in  = bus.s_valid_i & s_ready_q;
    assign xfer_out = m_valid_q & bus.m_ready_i;

    always_comb begin
        state_nxt      = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (xfer_in) begin
                    main_load = 1'b1;
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (xfer_in && !xfer_out) begin
                    skid_load = 1'b1;
                    state_nxt = ST_FULL;
                end else if (xfer_in && xfer_out) begin
                    main_load = 1'b1;
                end else if (xfer_out) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // s_ready_o is low here, so only the reader can move data.
                if (xfer_out) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    state_nxt      = ST_BUSY;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase
        // Clear voids any transfer in the same cycle; the data registers
        // see it through data_r, which outranks their load enable.
        if (clr_i) begin
            state_nxt = ST_EMPTY;
        end
    end

    assign main_d = main_from_skid ? skid_q : bus.s_data_i;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q   <= ST_EMPTY;
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
            level_q   <= 2'd0;
        end else if (cke_i) begin
            state_q   <= state_nxt;
            s_ready_q <= (state_nxt != ST_FULL);
            m_valid_q <= (state_nxt != ST_EMPTY);
            level_q   <= level_of(state_nxt);
        end
    end

    reg_skid_reader_data_reg #(
        .DATA_W  (DATA_W),
        .RST_VAL (RST_VAL)
    ) u_main_reg (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .cke_i  (cke_i),
        .data_e (main_load),
        .data_r (clr_i),
        .d      (main_d),
        .q      (main_q)
    );

    reg_skid_reader_data_reg #(
        .DATA_W  (DATA_W),
        .RST_VAL (RST_VAL)
    ) u_skid_reg (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .cke_i  (cke_i),
        .data_e (skid_load),
        .data_r (clr_i),
        .d      (bus.s_data_i),
        .q      (skid_q)
    );

    assign bus.s_ready_o = s_ready_q;
    assign bus.m_valid_o = m_valid_q;
    assign bus.m_data_o  = main_q;
    assign bus.level_o   = level_q;

endmodule

// File: tb/tb_reg_skid_reader.sv
// tb/tb_reg_skid_reader.sv - self-checking bench for reg_skid_reader
module tb_reg_skid_reader;

    localparam int DW = 21;

    logic clk;
    logic arst;
    logic cke;
    logic clr;
    int   checks;
    int   failures;

    reg_skid_reader_if #(.DATA_W(DW)) bus ();

    reg_skid_reader #(.DATA_W(DW), .RST_VAL('0)) dut (
        .clk_i  (clk),
        .arst_i (arst),
        .cke_i  (cke),
        .clr_i  (clr),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string name, input logic [1:0] lvl,
                                input logic rdy, input logic vld, input logic [DW-1:0] dat);
        checks++;
        if (bus.level_o !== lvl || bus.s_ready_o !== rdy || bus.m_valid_o !== vld
            || (vld && bus.m_data_o !== dat)) begin
            failures++;
            $display("FAIL %s: got level=%0d rdy=%b vld=%b data=%h, want level=%0d rdy=%b vld=%b data=%h",
                     name, bus.level_o, bus.s_ready_o, bus.m_valid_o, bus.m_data_o, lvl, rdy, vld, dat);
        end
    endtask

    task automatic idle_inputs();
        bus.s_valid_i = 1'b0;
        bus.s_data_i  = '0;
        bus.m_ready_i = 1'b0;
        cke = 1'b1;
        clr = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        arst = 1'b1;
        tick();
        tick();
        arst = 1'b0;
        tick();
        expect_state("reset_state", 2'd0, 1'b1, 1'b0, '0);
        checks++;
        if (bus.m_data_o !== 21'h0) begin
            failures++;
            $display("FAIL reset_data: got %h want 0", bus.m_data_o);
        end
        // fill to FULL then pulse arst between edges
        bus.s_valid_i = 1'b1; bus.s_data_i = 21'h5A;
        tick();
        bus.s_data_i = 21'h5B;
        tick();
        expect_state("reset_fill_full", 2'd2, 1'b0, 1'b1, 21'h5A);
        bus.s_valid_i = 1'b0;
        arst = 1'b1;
        #2;
        arst = 1'b0;
        tick();
        expect_state("arst_mid_full", 2'd0, 1'b1, 1'b0, '0);
        checks++;
        if (bus.m_data_o !== 21'h0) begin
            failures++;
            $display("FAIL arst_data: got %h want 0", bus.m_data_o);
        end
    endtask

    task automatic test_stream();
        idle_inputs();
        bus.m_ready_i = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            bus.s_valid_i = 1'b1;
            bus.s_data_i  = DW'(i);
            tick();
            expect_state($sformatf("stream_%0d", i), 2'd1, 1'b1, 1'b1, DW'(i));
        end
        bus.s_valid_i = 1'b0;
        tick();
        expect_state("stream_drained", 2'd0, 1'b1, 1'b0, '0);
    endtask

    task automatic test_backpressure();
        idle_inputs();
        bus.s_valid_i = 1'b1; bus.s_data_i = 21'hAA;
        tick();
        expect_state("bp_one", 2'd1, 1'b1, 1'b1, 21'hAA);
        bus.s_data_i = 21'hBB;
        tick();
        expect_state("bp_full", 2'd2, 1'b0, 1'b1, 21'hAA);
        bus.s_data_i = 21'hCC;
        tick();
        expect_state("bp_cc_ignored", 2'd2, 1'b0, 1'b1, 21'hAA);
        bus.m_ready_i = 1'b1;
        tick();
        expect_state("bp_out_aa", 2'd1, 1'b1, 1'b1, 21'hBB);
        tick();
        expect_state("bp_out_bb_in_cc", 2'd1, 1'b1, 1'b1, 21'hCC);
        bus.s_valid_i = 1'b0;
        tick();
        expect_state("bp_drained", 2'd0, 1'b1, 1'b0, '0);
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        bus.s_valid_i = 1'b1; bus.s_data_i = 21'h11;
        tick();
        expect_state("b2b_hold", 2'd1, 1'b1, 1'b1, 21'h11);
        bus.s_data_i = 21'h22; bus.m_ready_i = 1'b1;
        tick();
        expect_state("b2b_swap", 2'd1, 1'b1, 1'b1, 21'h22);
        bus.s_valid_i = 1'b0;
        tick();
        expect_state("b2b_drained", 2'd0, 1'b1, 1'b0, '0);
    endtask

    task automatic test_clr_full();
        idle_inputs();
        bus.s_valid_i = 1'b1; bus.s_data_i = 21'h31;
        tick();
        bus.s_data_i = 21'h32;
        tick();
        expect_state("clr_pre_full", 2'd2, 1'b0, 1'b1, 21'h31);
        clr = 1'b1; bus.m_ready_i = 1'b1; bus.s_data_i = 21'h33;
        tick();
        expect_state("clr_empty", 2'd0, 1'b1, 1'b0, '0);
        checks++;
        if (bus.m_data_o !== 21'h0) begin
            failures++;
            $display("FAIL clr_data: got %h want 0", bus.m_data_o);
        end
        clr = 1'b0; bus.s_valid_i = 1'b0;
        tick();
        expect_state("clr_stays_empty", 2'd0, 1'b1, 1'b0, '0);
    endtask

    task automatic test_cke();
        idle_inputs();
        bus.s_valid_i = 1'b1; bus.s_data_i = 21'h33;
        tick();
        expect_state("cke_busy", 2'd1, 1'b1, 1'b1, 21'h33);
        cke = 1'b0; bus.s_data_i = 21'h44; bus.m_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_state($sformatf("cke_frozen_%0d", i), 2'd1, 1'b1, 1'b1, 21'h33);
        end
        cke = 1'b1;
        tick();
        expect_state("cke_resume", 2'd1, 1'b1, 1'b1, 21'h44);
        bus.s_valid_i = 1'b0;
        tick();
        expect_state("cke_drained", 2'd0, 1'b1, 1'b0, '0);
    endtask

    task automatic test_random();
        logic [DW-1:0] q[$];
        logic          do_in;
        logic          do_out;
        idle_inputs();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            bus.s_valid_i = 1'($urandom_range(0, 1));
            bus.m_ready_i = 1'($urandom_range(0, 1));
            bus.s_data_i  = DW'($urandom);
            do_in  = bus.s_valid_i & bus.s_ready_o;
            do_out = bus.m_valid_o & bus.m_ready_i;
            if (do_out) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL rnd_spurious cycle %0d: got data=%h want no valid", cyc, bus.m_data_o);
                end else begin
                    if (bus.m_data_o !== q[0]) begin
                        failures++;
                        $display("FAIL rnd_data cycle %0d: got %h want %h", cyc, bus.m_data_o, q[0]);
                    end
                    void'(q.pop_front());
                end
            end
            if (do_in) q.push_back(bus.s_data_i);
            tick();
            checks++;
            if (bus.level_o !== 2'(q.size()) || bus.level_o === 2'd3
                || bus.m_valid_o !== (q.size() != 0) || bus.s_ready_o !== (q.size() < 2)) begin
                failures++;
                $display("FAIL rnd_level cycle %0d: got level=%0d vld=%b rdy=%b want level=%0d",
                         cyc, bus.level_o, bus.m_valid_o, bus.s_ready_o, q.size());
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        arst     = 1'b1;
        idle_inputs();
        test_reset();
        test_stream();
        test_backpressure();
        test_back_to_back();
        test_clr_full();
        test_cke();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
